lfsr_run_controller: RTL and testbench

//   Command-driven sequencer around the 64-bit XNOR Fibonacci LFSR used by our test designs.

---
 rtl/lfsr_run_controller.sv | 136 +++++++++++++
 tb/tb_lfsr_run_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_run_controller.sv
// Command-driven sequencer around a 64-bit XNOR Fibonacci LFSR.
// Accepts CLEAR/LOAD/STEP/FREE over valid/ready and signals completion with a DONE pulse.
module lfsr_run_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [63:0]      cmd_seed_i,
    input  logic [CNT_W-1:0] cmd_count_i,
    input  logic             abort_i,
    output logic [63:0]      output_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic             locked_o,
    output logic [CNT_W-1:0] total_o
);

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STEP  = 2'd2,
        OP_FREE  = 2'd3
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // All-ones is a fixed point of this XNOR feedback.
    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        lfsr_next = {~(s[0] ^ s[8] ^ s[13] ^ s[31]), s[63:1]};
    endfunction

    state_e            state_q;
    logic [63:0]       lfsr_q;
    logic [63:0]       lfsr_d;
    logic [CNT_W-1:0]  remain_q;
    logic [CNT_W-1:0]  total_q;
    logic [CNT_W-1:0]  total_d;
    logic              free_q;
    logic              done_q;
    logic              aborted_q;
    logic              accept_s;

    assign lfsr_d      = lfsr_next(lfsr_q);
    assign total_d     = total_q + CNT_ONE;
    assign cmd_ready_o = (state_q == S_IDLE) && !rst_i;
    assign accept_s    = cmd_valid_i && cmd_ready_o;

    assign output_o  = lfsr_q;
    assign busy_o    = (state_q == S_RUN);
    assign done_o    = done_q;
    assign aborted_o = aborted_q;
    assign locked_o  = &lfsr_q;
    assign total_o   = total_q;

    // Controller FSM: command decode in IDLE, one shift per clock in RUN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            lfsr_q    <= 64'h0;
            remain_q  <= '0;
            total_q   <= '0;
            free_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        case (cmd_op_i)
                            OP_CLEAR: begin
                                lfsr_q  <= 64'h0;
                                total_q <= '0;
                                done_q  <= 1'b1;
                            end
                            OP_LOAD: begin
                                lfsr_q <= cmd_seed_i;
                                done_q <= 1'b1;
                            end
                            OP_STEP: begin
                                if (cmd_count_i == '0) begin
                                    done_q <= 1'b1;
                                end else begin
                                    remain_q <= cmd_count_i;
                                    free_q   <= 1'b0;
                                    state_q  <= S_RUN;
                                end
                            end
                            OP_FREE: begin
                                free_q  <= 1'b1;
                                state_q <= S_RUN;
                            end
                            default: begin
                                state_q <= S_IDLE;
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    // Abort outranks the shift, including the final STEP shift.
                    if (abort_i) begin
                        state_q   <= S_IDLE;
                        remain_q  <= '0;
                        free_q    <= 1'b0;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                    end else begin
                        lfsr_q  <= lfsr_d;
                        total_q <= total_d;
                        if (!free_q) begin
                            remain_q <= remain_q - CNT_ONE;
                            if (remain_q == CNT_ONE) begin
                                state_q <= S_IDLE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_run_controller.sv
// Self-checking bench for lfsr_run_controller: vector table, corner-case sequences
// and randomized commands checked against a command-level reference model.
module tb_lfsr_run_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [63:0] cmd_seed;
    logic [15:0] cmd_count;
    logic        abort;
    logic [63:0] out;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        locked;
    logic [15:0] total;

    int total_n = 0;
    int bad_n   = 0;

    logic [63:0] m_out;
    logic [15:0] m_total;

    always #5 clk = ~clk;

    lfsr_run_controller #(.CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_seed_i(cmd_seed), .cmd_count_i(cmd_count),
        .abort_i(abort), .output_o(out), .busy_o(busy), .done_o(done),
        .aborted_o(aborted), .locked_o(locked), .total_o(total)
    );

    typedef struct {
        logic [1:0]  op;
        logic [63:0] seed;
        logic [15:0] cnt;
        int          ab;
        logic [63:0] exp_out;
        logic [15:0] exp_total;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_step(input logic [63:0] s);
        logic fb;
        fb = ~(s[0] ^ s[8] ^ s[13] ^ s[31]);
        return {fb, s[63:1]};
    endfunction

    // Issue one command from IDLE, wait for DONE, compare against the model.
    // ab < 0 means no abort; otherwise abort is raised after ab shifts.
    task automatic do_cmd(input logic [1:0] op, input logic [63:0] seed,
                          input logic [15:0] cnt, input int ab);
        int   exp_lat;
        int   shifts;
        int   cyc;
        logic exp_ab;
        logic lock_run;
        logic got;
        exp_ab = 1'b0;
        shifts = 0;
        exp_lat = 1;
        lock_run = 1'b0;
        case (op)
            2'd0: begin m_out = 64'h0; m_total = 16'h0; end
            2'd1: m_out = seed;
            2'd2: begin
                if (ab >= 0 && ab < int'(cnt)) begin
                    shifts = ab; exp_ab = 1'b1; exp_lat = ab + 2;
                end else begin
                    shifts = int'(cnt); exp_lat = int'(cnt) + 1;
                end
                lock_run = (m_out == 64'hFFFF_FFFF_FFFF_FFFF) && (cnt != 16'd0);
            end
            default: begin
                shifts = ab; exp_ab = 1'b1; exp_lat = ab + 2;
                lock_run = (m_out == 64'hFFFF_FFFF_FFFF_FFFF);
            end
        endcase
        for (int k = 0; k < shifts; k++) m_out = ref_step(m_out);
        m_total = m_total + 16'(shifts);

        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_seed = seed; cmd_count = cnt; abort = 1'b0;
        #1 check("ready_idle", 64'(cmd_ready), 64'(1'b1));
        @(posedge clk);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 70000) begin
            @(negedge clk);
            cyc++;
            cmd_valid = 1'b0;
            if (cyc == 1) check("busy_first", 64'(busy), 64'(exp_lat > 1));
            if (lock_run && !done) begin
                total_n++;
                if (locked !== 1'b1) begin
                    bad_n++;
                    $display("FAIL locked_run: got %b expected 1 at cycle %0d", locked, cyc);
                end
            end
            if (done) got = 1'b1;
            else if (ab >= 0 && cyc == ab + 1) abort = 1'b1;
        end
        abort = 1'b0;
        if (!got) begin
            check("done_timeout", 64'(got), 64'(1'b1));
        end else begin
            check("latency", 64'(cyc), 64'(exp_lat));
            check("output", out, m_out);
            check("total", 64'(total), 64'(m_total));
            check("aborted", 64'(aborted), 64'(exp_ab));
            check("locked", 64'(locked), 64'(m_out == 64'hFFFF_FFFF_FFFF_FFFF));
            check("ready_done", 64'(cmd_ready), 64'(1'b1));
        end
    endtask

    initial begin
        int cyc;
        int ready_hi;
        logic got;
        logic [1:0] rop;
        logic [63:0] rseed;
        int rab;

        tbl[0]  = '{2'd2, 64'h0, 16'd2, -1, 64'hC000_0000_0000_0000, 16'd2};
        tbl[1]  = '{2'd2, 64'h0, 16'd0, -1, 64'hC000_0000_0000_0000, 16'd2};
        tbl[2]  = '{2'd0, 64'h0, 16'd0, -1, 64'h0, 16'd0};
        tbl[3]  = '{2'd2, 64'h0, 16'd4, -1, 64'hF000_0000_0000_0000, 16'd4};
        tbl[4]  = '{2'd1, 64'h101, 16'd0, -1, 64'h101, 16'd4};
        tbl[5]  = '{2'd2, 64'h0, 16'd1, -1, 64'h8000_0000_0000_0080, 16'd5};
        tbl[6]  = '{2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 16'd0, -1, 64'hFFFF_FFFF_FFFF_FFFF, 16'd5};
        tbl[7]  = '{2'd2, 64'h0, 16'd5, -1, 64'hFFFF_FFFF_FFFF_FFFF, 16'd10};
        tbl[8]  = '{2'd0, 64'h0, 16'd0, -1, 64'h0, 16'd0};
        tbl[9]  = '{2'd3, 64'h0, 16'd0, 10, 64'hFFC0_0000_0000_0000, 16'd10};
        tbl[10] = '{2'd2, 64'h0, 16'd6, 5, 64'hFFFE_0000_0000_0000, 16'd15};
        tbl[11] = '{2'd2, 64'h0, 16'd3, 1, 64'hFFFF_0000_0000_0000, 16'd16};

        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0; cmd_seed = 64'h0;
        cmd_count = 16'd0; abort = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_ready", 64'(cmd_ready), 64'(1'b0));
        end
        check("rst_out", out, 64'h0);
        check("rst_total", 64'(total), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_aborted", 64'(aborted), 64'h0);
        rst = 1'b0; cmd_valid = 1'b0;
        m_out = 64'h0; m_total = 16'h0;

        for (int i = 0; i < 12; i++) begin
            do_cmd(tbl[i].op, tbl[i].seed, tbl[i].cnt, tbl[i].ab);
            check($sformatf("tbl%0d_out", i), out, tbl[i].exp_out);
            check($sformatf("tbl%0d_total", i), 64'(total), 64'(tbl[i].exp_total));
        end

        // STEP 100 with a CLEAR held on the bus: no accept until DONE.
        do_cmd(2'd0, 64'h0, 16'd0, -1);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_count = 16'd100;
        @(posedge clk);
        cyc = 0; ready_hi = 0; got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            cmd_op = 2'd0;
            if (cyc == 2) check("t5_first_shift", out, 64'h8000_0000_0000_0000);
            if (done) got = 1'b1;
            else if (cmd_ready) ready_hi++;
        end
        for (int k = 0; k < 100; k++) m_out = ref_step(m_out);
        m_total = 16'd100;
        check("t5_latency", 64'(cyc), 64'd101);
        check("t5_ready_mid_run", 64'(ready_hi), 64'd0);
        check("t5_ready_done", 64'(cmd_ready), 64'(1'b1));
        check("t5_out", out, m_out);
        check("t5_total", 64'(total), 64'(m_total));
        @(negedge clk);
        cmd_valid = 1'b0;
        check("t5_clear_out", out, 64'h0);
        check("t5_clear_done", 64'(done), 64'(1'b1));
        check("t5_clear_total", 64'(total), 64'h0);
        m_out = 64'h0; m_total = 16'h0;

        // Reset in the middle of a STEP 50.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_count = 16'd50;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (18) @(negedge clk);
        check("t6_running", 64'(busy), 64'(1'b1));
        rst = 1'b1;
        #1 check("t6_ready_rst", 64'(cmd_ready), 64'(1'b0));
        @(negedge clk);
        check("t6_out", out, 64'h0);
        check("t6_total", 64'(total), 64'h0);
        check("t6_busy", 64'(busy), 64'h0);
        check("t6_done", 64'(done), 64'h0);
        check("t6_ready_rst2", 64'(cmd_ready), 64'(1'b0));
        rst = 1'b0;
        #1 check("t6_ready_after", 64'(cmd_ready), 64'(1'b1));
        @(negedge clk);
        check("t6_no_done", 64'(done), 64'h0);
        m_out = 64'h0; m_total = 16'h0;

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            rseed = ($urandom_range(0, 4) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            rab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : -1;
            if (rop == 2'd3) rab = int'($urandom_range(0, 15));
            do_cmd(rop, rseed, 16'($urandom_range(0, 20)), rab);
        end

        // TOTAL wraps: 65537 locked shifts from a cleared counter leaves TOTAL=1.
        do_cmd(2'd0, 64'h0, 16'd0, -1);
        do_cmd(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 16'd0, -1);
        do_cmd(2'd3, 64'h0, 16'd0, 65537);
        check("wrap_total", 64'(total), 64'd1);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
